// File: rtl/jt89_decim.sv
// Second-order CIC decimator, ratio 16, for the JT89 x16 mixer stream.
// Unsigned modulo-2^(bw+8) integrators and combs; output truncated by 256.
module jt89_decim #(
    parameter int bw = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic [bw-1:0] din,
    output logic [bw-1:0] dout,
    output logic          dout_valid,
    output logic [3:0]    phase
);
    localparam int W = bw + 8;

    logic [W-1:0]  integ1_q, integ1_d;
    logic [W-1:0]  integ2_q, integ2_d;
    logic [W-1:0]  z1_q, z1_d;
    logic [W-1:0]  z2_q, z2_d;
    logic [W-1:0]  c1_q, c1_d;
    logic          tick_d_q, tick_d_d;
    logic [3:0]    phase_q, phase_d;
    logic [bw-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          tick;
    logic [W-1:0]  c2;

    always_comb begin
        integ1_d     = integ1_q;
        integ2_d     = integ2_q;
        phase_d      = phase_q;
        c1_d         = c1_q;
        z1_d         = z1_q;
        z2_d         = z2_q;
        dout_d       = dout_q;
        tick         = clk_en && (phase_q == 4'd15);
        c2           = c1_q - z2_q;
        tick_d_d     = tick;
        dout_valid_d = tick_d_q;

        if (clk_en) begin
            integ1_d = integ1_q + {{8{1'b0}}, din};
            integ2_d = integ2_q + integ1_q;
            phase_d  = phase_q + 4'd1;
        end
        if (tick) begin
            c1_d = integ2_q - z1_q;
            z1_d = integ2_q;
        end
        // Second comb runs one cycle after the tick, whatever clk_en does then.
        if (tick_d_q) begin
            z2_d   = c1_q;
            dout_d = bw'(c2 >> 8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ1_q     <= '0;
            integ2_q     <= '0;
            z1_q         <= '0;
            z2_q         <= '0;
            c1_q         <= '0;
            tick_d_q     <= 1'b0;
            phase_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            integ1_q     <= integ1_d;
            integ2_q     <= integ2_d;
            z1_q         <= z1_d;
            z2_q         <= z2_d;
            c1_q         <= c1_d;
            tick_d_q     <= tick_d_d;
            phase_q      <= phase_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign phase      = phase_q;

endmodule
